// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: in-flight destination scoreboard, RAW/memory stall vector, stall counter.
// Optional macro HAZARD_FWD_EN: forwarding present, so only load-use hazards on entry 0 stall.
module hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic             id_reg1_read_i,
    input  logic [4:0]       id_reg1_addr_i,
    input  logic             id_reg2_read_i,
    input  logic [4:0]       id_reg2_addr_i,
    input  logic             id_wreg_i,
    input  logic [4:0]       id_wd_i,
    input  logic             id_load_i,
    input  logic             mem_stall_req_i,
    input  logic             flush_i,
    output logic [5:0]       stall_o,
    output logic             hazard_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        MWAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DEPTH-1:0] sb_vld;
    logic [4:0]       sb_addr [DEPTH];
    logic             m1, m2, raw;

`ifdef HAZARD_FWD_EN
    // Only the youngest entry's load flag matters once forwarding covers the rest.
    logic sb_load0;

    always_comb begin
        m1 = sb_vld[0] & sb_load0 & (sb_addr[0] == id_reg1_addr_i) & (id_reg1_addr_i != 5'd0);
        m2 = sb_vld[0] & sb_load0 & (sb_addr[0] == id_reg2_addr_i) & (id_reg2_addr_i != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && !mem_stall_req_i)
            sb_load0 <= id_load_i;
    end
`else
    logic unused_load;
    assign unused_load = id_load_i;

    always_comb begin
        m1 = 1'b0;
        m2 = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (sb_vld[k] && sb_addr[k] == id_reg1_addr_i && id_reg1_addr_i != 5'd0)
                m1 = 1'b1;
            if (sb_vld[k] && sb_addr[k] == id_reg2_addr_i && id_reg2_addr_i != 5'd0)
                m2 = 1'b1;
        end
    end
`endif

    assign raw      = id_valid_i & ((id_reg1_read_i & m1) | (id_reg2_read_i & m2));
    assign hazard_o = raw & ~flush_i;

    always_comb begin
        stall_o   = '0;
        state_nxt = RUN;
        if (flush_i) begin
            stall_o   = '0;
            state_nxt = RUN;
        end else if (mem_stall_req_i) begin
            stall_o   = 6'b011111;
            state_nxt = MWAIT;
        end else if (hazard_o) begin
            stall_o   = 6'b000111;
            state_nxt = HAZ;
        end
    end

    // A hazard shifts in an invalid entry so the producer keeps draining.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            sb_vld <= '0;
        end else if (!mem_stall_req_i) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb_vld[k]  <= sb_vld[k-1];
                sb_addr[k] <= sb_addr[k-1];
            end
            sb_vld[0]  <= id_valid_i & id_wreg_i & ~hazard_o;
            sb_addr[0] <= id_wd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (stall_o != 6'd0 && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second CNT_W=4 instance checks counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_load_i;
    logic [4:0] id_reg1_addr_i, id_reg2_addr_i, id_wd_i;
    logic       mem_stall_req_i, flush_i;
    logic [5:0] stall_o, stall_s;
    logic       hazard_o, hazard_s;
    logic [1:0] state_o, state_s;
    logic [31:0] stall_cnt_o;
    logic [3:0]  cnt_s;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NRAW  = FWD ? 0 : 3;
    localparam int NLOAD = FWD ? 1 : 3;
    localparam int NREM  = FWD ? 0 : 2;
    localparam logic [5:0] HSTALL = FWD ? 6'd0 : 6'b000111;

    always #5 clk = ~clk;

    hazard_ctrl #(.DEPTH(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
        .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
        .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
        .id_wreg_i(id_wreg_i), .id_wd_i(id_wd_i), .id_load_i(id_load_i),
        .mem_stall_req_i(mem_stall_req_i), .flush_i(flush_i),
        .stall_o(stall_o), .hazard_o(hazard_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    hazard_ctrl #(.DEPTH(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
        .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
        .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
        .id_wreg_i(id_wreg_i), .id_wd_i(id_wd_i), .id_load_i(id_load_i),
        .mem_stall_req_i(mem_stall_req_i), .flush_i(flush_i),
        .stall_o(stall_s), .hazard_o(hazard_s), .state_o(state_s), .stall_cnt_o(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_in;
        id_valid_i = 0; id_reg1_read_i = 0; id_reg1_addr_i = 0;
        id_reg2_read_i = 0; id_reg2_addr_i = 0; id_wreg_i = 0;
        id_wd_i = 0; id_load_i = 0; mem_stall_req_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic r1rd, input logic [4:0] r1a, input logic r2rd,
                         input logic [4:0] r2a, input logic wr, input logic [4:0] wd,
                         input logic ld);
        id_valid_i = 1; id_reg1_read_i = r1rd; id_reg1_addr_i = r1a;
        id_reg2_read_i = r2rd; id_reg2_addr_i = r2a; id_wreg_i = wr;
        id_wd_i = wd; id_load_i = ld;
    endtask

    task automatic drain;
        idle_in();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        rst = 1;
        tick(); tick();
        rst = 0;
        settle();
        chk("reset_stall", stall_o, 0);
        chk("reset_state", state_o, 0);
        chk("reset_cnt", stall_cnt_o, 0);
        chk("reset_hazard", hazard_o, 0);

        // Back-to-back RAW: ori r3, then andi reading r3
        issue(0, 0, 0, 0, 1, 5'd3, 0);
        settle();
        chk("raw_producer_nostall", stall_o, 0);
        tick();
        issue(1, 5'd3, 0, 0, 1, 5'd4, 0);
        settle();
        for (int i = 0; i < NRAW; i++) begin
            chk("raw_stall", stall_o, 6'b000111);
            chk("raw_hazard", hazard_o, 1);
            if (i > 0) chk("raw_state_haz", state_o, 1);
            tick();
        end
        chk("raw_release", stall_o, 0);
        chk("raw_release_hazard", hazard_o, 0);
        exp_cnt += NRAW;
        chk("raw_cnt", stall_cnt_o, exp_cnt);
        tick();
        chk("raw_state_run", state_o, 0);
        drain();

        // Load-use on r5
        issue(0, 0, 0, 0, 1, 5'd5, 1);
        tick();
        issue(0, 0, 1, 5'd5, 0, 0, 0);
        settle();
        for (int i = 0; i < NLOAD; i++) begin
            chk("load_stall", stall_o, 6'b000111);
            tick();
        end
        chk("load_release", stall_o, 0);
        exp_cnt += NLOAD;
        chk("load_cnt", stall_cnt_o, exp_cnt);
        drain();

        // Load r5, reader of r6: no hazard
        issue(0, 0, 0, 0, 1, 5'd5, 1);
        tick();
        issue(1, 5'd6, 1, 5'd6, 0, 0, 0);
        settle();
        chk("r6_nohazard", hazard_o, 0);
        chk("r6_nostall", stall_o, 0);
        drain();

        // Write r0, read r0: register 0 never stalls
        issue(0, 0, 0, 0, 1, 5'd0, 1);
        tick();
        issue(1, 5'd0, 1, 5'd0, 0, 0, 0);
        settle();
        chk("r0_nohazard", hazard_o, 0);
        chk("r0_nostall", stall_o, 0);
        drain();

        // Memory freeze while r3 sits in entry 1
        issue(0, 0, 0, 0, 1, 5'd3, 0);
        tick();
        idle_in();
        tick();
        issue(1, 5'd3, 0, 0, 0, 0, 0);
        mem_stall_req_i = 1;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("freeze_stall", stall_o, 6'b011111);
            chk("freeze_hazard", hazard_o, FWD ? 0 : 1);
            if (i > 0) chk("freeze_state", state_o, 2);
            tick();
        end
        mem_stall_req_i = 0;
        settle();
        chk("freeze_state_after", state_o, 2);
        for (int i = 0; i < NREM; i++) begin
            chk("resume_stall", stall_o, 6'b000111);
            tick();
        end
        chk("resume_release", stall_o, 0);
        exp_cnt += 4 + NREM;
        chk("freeze_cnt", stall_cnt_o, exp_cnt);
        drain();

        // Flush in second hazard cycle
        issue(0, 0, 0, 0, 1, 5'd3, 0);
        tick();
        issue(1, 5'd3, 0, 0, 0, 0, 0);
        settle();
        chk("flush_pre_stall", stall_o, HSTALL);
        tick();
        flush_i = 1;
        settle();
        chk("flush_stall", stall_o, 0);
        chk("flush_hazard", hazard_o, 0);
        tick();
        flush_i = 0;
        settle();
        chk("flush_after_stall", stall_o, 0);
        chk("flush_after_hazard", hazard_o, 0);
        chk("flush_after_state", state_o, 0);
        exp_cnt += FWD ? 0 : 1;
        chk("flush_cnt", stall_cnt_o, exp_cnt);

        // Flush and mem stall together: flush wins
        flush_i = 1;
        mem_stall_req_i = 1;
        settle();
        chk("flushmem_stall", stall_o, 0);
        tick();
        chk("flushmem_state", state_o, 0);
        chk("flushmem_cnt", stall_cnt_o, exp_cnt);
        drain();

        // Reset during a stall
        issue(0, 0, 0, 0, 1, 5'd3, 0);
        tick();
        issue(1, 5'd3, 0, 0, 0, 0, 0);
        settle();
        chk("rststall_pre", stall_o, HSTALL);
        rst = 1;
        tick();
        rst = 0;
        settle();
        exp_cnt = 0;
        chk("rststall_stall", stall_o, 0);
        chk("rststall_hazard", hazard_o, 0);
        chk("rststall_state", state_o, 0);
        chk("rststall_cnt", stall_cnt_o, 0);
        chk("rststall_cnt_sat", cnt_s, 0);

        // Counter saturation on the 4-bit instance
        idle_in();
        mem_stall_req_i = 1;
        repeat (14) tick();
        chk("sat_cnt_14", cnt_s, 4'hE);
        repeat (6) tick();
        exp_cnt += 20;
        chk("sat_cnt_stick", cnt_s, 4'hF);
        chk("wide_cnt_20", stall_cnt_o, exp_cnt);
        chk("sat_state", state_s, 2);
        idle_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
